uart_word_arbiter: RTL and testbench

UART_WORD_ARBITER -- requirements
Module: uart_word_arbiter

---
 rtl/uart_word_arbiter_pkg.sv | 20 ++
 rtl/uart_word_arbiter_rr_grant2.sv | 18 +
 rtl/uart_word_arbiter.sv | 100 ++++++++++
 tb/tb_uart_word_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_word_arbiter_pkg.sv
// Shared definitions for the two-requester word-to-byte UART arbiter.
// Holds the FSM encoding and the byte-count sizing helpers.
package uart_word_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    function automatic int nbytes_of(input int nbits, input int dbits);
        return nbits / dbits;
    endfunction

    // Byte counter must stay at least one bit wide even for single-byte words.
    function automatic int cnt_width(input int nbytes);
        return (nbytes <= 1) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/uart_word_arbiter_rr_grant2.sv
// Two-way round-robin grant: the requester not served last wins a contest.
// A lone valid requester always wins.
module rr_grant2 (
    input  logic       v0,
    input  logic       v1,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (v0 && (!v1 || last))
            grant[0] = 1'b1;
        else if (v1)
            grant[1] = 1'b1;
    end

endmodule

// File: rtl/uart_word_arbiter.sv
// Accepts NBITS words from two round-robin requesters and serializes each one
// LSB-first as DBITS bytes into a start/done handshaked UART transmitter.
module uart_word_arbiter
    import uart_word_arbiter_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int DBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r0_valid,
    input  logic [NBITS-1:0] r0_data,
    output logic             r0_ready,
    input  logic             r1_valid,
    input  logic [NBITS-1:0] r1_data,
    output logic             r1_ready,
    output logic [DBITS-1:0] tx_Data,
    output logic             tx_start,
    input  logic             tx_done,
    output logic             busy,
    output logic             grant_id
);

    localparam int NBYTES = nbytes_of(NBITS, DBITS);
    localparam int CW     = cnt_width(NBYTES);
    localparam logic [CW-1:0] LAST_K = CW'(NBYTES - 1);

    state_t           state;
    logic [NBITS-1:0] word;
    logic [CW-1:0]    k;
    logic             last;
    logic [1:0]       grant;
    logic             accept;
    logic [NBITS-1:0] sel_data;

    rr_grant2 u_rr_grant2 (
        .v0    (r0_valid),
        .v1    (r1_valid),
        .last  (last),
        .grant (grant)
    );

    // Ready is combinational so a requester sees acceptance in the same cycle.
    assign r0_ready = (state == IDLE) && !reset && grant[0];
    assign r1_ready = (state == IDLE) && !reset && grant[1];
    assign accept   = r0_ready || r1_ready;
    assign sel_data = grant[1] ? r1_data : r0_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            word     <= '0;
            k        <= '0;
            last     <= 1'b1;
            tx_Data  <= '0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
            grant_id <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_start <= 1'b0;
                    if (accept) begin
                        word     <= sel_data;
                        grant_id <= grant[1];
                        last     <= grant[1];
                        k        <= '0;
                        tx_Data  <= sel_data[DBITS-1:0];
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    tx_start <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (tx_done) begin
                        if (k == LAST_K) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            k        <= k + 1'b1;
                            tx_Data  <= word[(int'(k) + 1) * DBITS +: DBITS];
                            tx_start <= 1'b1;
                            state    <= SEND;
                        end
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_arbiter.sv
// Directed bench for uart_word_arbiter: a queue-based transaction model checked
// every cycle, plus literal byte/grant sequences for each scenario.
module tb_uart_word_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic [31:0] r0_data = '0, r1_data = '0;
    logic        r0_ready, r1_ready;
    logic [7:0]  tx_Data;
    logic        tx_start, busy, grant_id;
    logic        tx_done;
    logic        tx_done_man = 1'b0, tx_done_auto = 1'b0;
    logic        auto_en = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    assign tx_done = tx_done_man | tx_done_auto;

    uart_word_arbiter #(.NBITS(32), .DBITS(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .r0_valid (r0_valid),
        .r0_data  (r0_data),
        .r0_ready (r0_ready),
        .r1_valid (r1_valid),
        .r1_data  (r1_data),
        .r1_ready (r1_ready),
        .tx_Data  (tx_Data),
        .tx_start (tx_start),
        .tx_done  (tx_done),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting at %0t", nm, $time);
    endtask

    // Model: a word in flight is the queue of its remaining bytes.
    logic [7:0] mq[$];
    logic       m_start = 1'b0;
    logic [7:0] m_cur = '0;
    logic       m_gid = 1'b0;
    logic       m_last = 1'b1;
    logic [7:0] obs[$];
    logic       obs_gid[$];
    logic       acc_log[$];

    initial begin
        logic e0, e1;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (reset) begin
                mq.delete();
                m_start = 1'b0;
                m_cur   = '0;
                m_gid   = 1'b0;
                m_last  = 1'b1;
            end
            e0 = 1'b0;
            e1 = 1'b0;
            if (!reset && mq.size() == 0) begin
                if (r0_valid && r1_valid) begin
                    if (m_last) e0 = 1'b1; else e1 = 1'b1;
                end else begin
                    e0 = r0_valid;
                    e1 = r1_valid;
                end
            end
            check("r0_ready", r0_ready, e0);
            check("r1_ready", r1_ready, e1);
            check("ready_exclusive", r0_ready & r1_ready, 0);
            check("busy", busy, mq.size() != 0);
            check("tx_start", tx_start, m_start);
            check("tx_Data", tx_Data, m_cur);
            check("grant_id", grant_id, m_gid);
            if (tx_start === 1'b1) begin
                obs.push_back(tx_Data);
                obs_gid.push_back(grant_id);
            end
            if (r0_ready === 1'b1) acc_log.push_back(1'b0);
            if (r1_ready === 1'b1) acc_log.push_back(1'b1);
            if (!reset) begin
                if (mq.size() == 0) begin
                    if (e0 || e1) begin
                        w = e1 ? r1_data : r0_data;
                        for (int i = 0; i < 4; i++) mq.push_back(w[8*i +: 8]);
                        m_cur   = mq[0];
                        m_start = 1'b1;
                        m_gid   = e1;
                        m_last  = e1;
                    end
                end else if (m_start) begin
                    m_start = 1'b0;
                end else if (tx_done) begin
                    void'(mq.pop_front());
                    if (mq.size() != 0) begin
                        m_cur   = mq[0];
                        m_start = 1'b1;
                    end
                end
            end
        end
    end

    // Transmitter stand-in: done pulse three cycles after each start.
    initial begin
        int dcnt;
        dcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            tx_done_auto = 1'b0;
            if (reset) begin
                dcnt = 0;
            end else begin
                if (dcnt > 0) begin
                    dcnt--;
                    if (dcnt == 0) tx_done_auto = 1'b1;
                end
                if (auto_en && tx_start) dcnt = 3;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_accept(input int idx);
        int t;
        t = 0;
        while (t < 100) begin
            @(negedge clk);
            if ((idx == 0 ? r0_ready : r1_ready) === 1'b1) break;
            t++;
        end
        if (t == 100) timeout($sformatf("accept_r%0d", idx));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (t < 300) begin
            @(negedge clk);
            if (busy === 1'b0) break;
            t++;
        end
        if (t == 300) timeout("idle");
        @(posedge clk);
        #1;
    endtask

    task automatic check_bytes(input string nm, input logic [7:0] e [8],
                               input logic g [8], input int n);
        check({nm, "_count"}, obs.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < obs.size()) begin
                check($sformatf("%s_byte%0d", nm, i), obs[i], e[i]);
                check($sformatf("%s_gid%0d", nm, i), obs_gid[i], g[i]);
            end
        end
    endtask

    initial begin
        logic [7:0] e [8];
        logic       g [8];

        // Reset state, with a requester already valid.
        r0_valid = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_Data", tx_Data, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_r0_ready", r0_ready, 0);
        r0_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        // Single requester, DEADBEEF.
        obs.delete(); obs_gid.delete();
        r0_data = 32'hDEADBEEF; r0_valid = 1'b1;
        wait_accept(0);
        r0_valid = 1'b0;
        wait_idle();
        e = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00};
        g = '{0, 0, 0, 0, 0, 0, 0, 0};
        check_bytes("deadbeef", e, g, 4);
        check("deadbeef_busy_end", busy, 0);

        // Contest after reset: r0 first, then r1 back-to-back.
        do_reset();
        obs.delete(); obs_gid.delete();
        r0_data = 32'h11223344; r1_data = 32'hAABBCCDD;
        r0_valid = 1'b1; r1_valid = 1'b1;
        wait_accept(0);
        r0_valid = 1'b0;
        wait_accept(1);
        r1_valid = 1'b0;
        wait_idle();
        e = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        g = '{0, 0, 0, 0, 1, 1, 1, 1};
        check_bytes("contest", e, g, 8);

        // Continuous contest for four words: grants alternate.
        do_reset();
        acc_log.delete();
        r0_data = 32'h0A0B0C0D; r1_data = 32'h1A1B1C1D;
        r0_valid = 1'b1; r1_valid = 1'b1;
        begin
            int t;
            t = 0;
            while (t < 400 && acc_log.size() < 4) begin
                @(negedge clk);
                t++;
            end
            if (acc_log.size() < 4) timeout("four_accepts");
        end
        @(posedge clk);
        #1 r0_valid = 1'b0; r1_valid = 1'b0;
        wait_idle();
        check("rr_accepts", acc_log.size(), 4);
        if (acc_log.size() >= 4) begin
            check("rr_grant0", acc_log[0], 0);
            check("rr_grant1", acc_log[1], 1);
            check("rr_grant2", acc_log[2], 0);
            check("rr_grant3", acc_log[3], 1);
        end

        // tx_done while idle and during the start cycle must be ignored.
        do_reset();
        auto_en = 1'b0;
        obs.delete(); obs_gid.delete();
        tx_done_man = 1'b1;
        repeat (2) @(posedge clk);
        #1 tx_done_man = 1'b0;
        check("idle_done_no_start", obs.size(), 0);
        r0_data = 32'hA1B2C3D4; r0_valid = 1'b1;
        wait_accept(0);
        r0_valid = 1'b0;
        tx_done_man = 1'b1;
        @(posedge clk);
        #1 tx_done_man = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("send_done_ignored", obs.size(), 1);
        for (int i = 0; i < 4; i++) begin
            tx_done_man = 1'b1;
            @(posedge clk);
            #1 tx_done_man = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
        wait_idle();
        auto_en = 1'b1;
        e = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h00, 8'h00, 8'h00, 8'h00};
        g = '{0, 0, 0, 0, 0, 0, 0, 0};
        check_bytes("ignore_done", e, g, 4);

        // Reset mid-word aborts; the next word starts cleanly from byte 0.
        do_reset();
        obs.delete(); obs_gid.delete();
        r0_data = 32'h01020304; r0_valid = 1'b1;
        wait_accept(0);
        r0_valid = 1'b0;
        begin
            int t;
            t = 0;
            while (t < 100 && obs.size() < 2) begin
                @(negedge clk);
                t++;
            end
            if (obs.size() < 2) timeout("second_byte");
        end
        @(posedge clk);
        #2 reset = 1'b1; r1_valid = 1'b1; r1_data = 32'hCAFEF00D;
        #1;
        check("abort_busy", busy, 0);
        check("abort_tx_start", tx_start, 0);
        check("abort_tx_Data", tx_Data, 0);
        check("abort_grant_id", grant_id, 0);
        check("abort_r1_ready", r1_ready, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        obs.delete(); obs_gid.delete();
        wait_accept(1);
        r1_valid = 1'b0;
        wait_idle();
        e = '{8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h00, 8'h00, 8'h00, 8'h00};
        g = '{1, 1, 1, 1, 0, 0, 0, 0};
        check_bytes("after_abort", e, g, 4);

        // Requester data changing after acceptance does not disturb the word.
        do_reset();
        obs.delete(); obs_gid.delete();
        r0_data = 32'h12345678; r0_valid = 1'b1;
        wait_accept(0);
        r0_data = 32'h0; r0_valid = 1'b0;
        wait_idle();
        e = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00};
        g = '{0, 0, 0, 0, 0, 0, 0, 0};
        check_bytes("hold_word", e, g, 4);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got no summary expected one");
        $fatal(1);
    end

endmodule
